// File: rtl/multisim_client_quasi_static_push.sv
// Quasi-static value sender: pushes a slowly changing local bus to a multisim
// server through a vld/rdy push client, only on change, with optional
// rate limiting and coalescing of updates made while a send is in flight.

// Behavioural stand-in for the multisim push client: an always-ready sink.
module multisim_client_push #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  string                 server_runtime_directory,
  input  string                 server_name,
  input  logic                  data_vld,
  output logic                  data_rdy,
  input  logic [DATA_WIDTH-1:0] data
);

  logic unused_inputs;

  // Fold inputs the stand-in does not consume into one sink.
  always_comb begin
    unused_inputs = clk ^ data_vld ^ (^data)
                  ^ (server_name == "") ^ (server_runtime_directory == "");
  end

  assign data_rdy = 1'b1;

endmodule

module multisim_client_quasi_static_push #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned MIN_INTERVAL  = 0,
  parameter bit          PUSH_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  string                 server_runtime_directory,
  input  string                 server_name,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic [31:0]           push_count,
  output logic [31:0]           coalesce_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  // Holdoff load value: accept->next tx_vld spacing of MIN_INTERVAL cycles.
  localparam logic [31:0] HOLD_INIT = (MIN_INTERVAL > 1) ? 32'(MIN_INTERVAL - 1) : '0;

  state_t                state_q, state_d;
  logic                  tx_vld_q, tx_vld_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0] last_sent_q, last_sent_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  first_q, first_d;
  logic [31:0]           push_cnt_q, push_cnt_d;
  logic [31:0]           coal_cnt_q, coal_cnt_d;
  logic [31:0]           hold_cnt_q, hold_cnt_d;
  logic                  tx_rdy;

  multisim_client_push #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_push (
    .clk                      (clk),
    .server_runtime_directory (server_runtime_directory),
    .server_name              (server_name),
    .data_vld                 (tx_vld_q),
    .data_rdy                 (tx_rdy),
    .data                     (tx_data_q)
  );

  assign busy           = (state_q == SEND) || (state_q == HOLDOFF);
  assign push_count     = push_cnt_q;
  assign coalesce_count = coal_cnt_q;

  // Next-state, offer and counter logic.
  always_comb begin
    state_d     = state_q;
    tx_vld_d    = tx_vld_q;
    tx_data_d   = tx_data_q;
    last_sent_d = last_sent_q;
    first_d     = first_q;
    push_cnt_d  = push_cnt_q;
    coal_cnt_d  = coal_cnt_q;
    hold_cnt_d  = hold_cnt_q;

    if (busy && (data != data_q) && (coal_cnt_q != '1)) begin
      coal_cnt_d = coal_cnt_q + 32'd1;
    end

    unique case (state_q)
      IDLE: begin
        if ((data != last_sent_q) || first_q) begin
          tx_data_d = data;
          tx_vld_d  = 1'b1;
          first_d   = 1'b0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (tx_vld_q && tx_rdy) begin
          last_sent_d = tx_data_q;
          tx_vld_d    = 1'b0;
          if (push_cnt_q != '1) begin
            push_cnt_d = push_cnt_q + 32'd1;
          end
          if (MIN_INTERVAL > 1) begin
            hold_cnt_d = HOLD_INIT;
            state_d    = HOLDOFF;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLDOFF: begin
        // Leave on the edge where the counter reaches 0 so IDLE can
        // raise tx_vld exactly MIN_INTERVAL cycles after the accept.
        if (hold_cnt_q <= 32'd1) begin
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset abandons any open offer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_vld_q    <= 1'b0;
      tx_data_q   <= '0;
      last_sent_q <= '0;
      data_q      <= '0;
      first_q     <= PUSH_ON_RESET;
      push_cnt_q  <= '0;
      coal_cnt_q  <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tx_vld_q    <= tx_vld_d;
      tx_data_q   <= tx_data_d;
      last_sent_q <= last_sent_d;
      data_q      <= data;
      first_q     <= first_d;
      push_cnt_q  <= push_cnt_d;
      coal_cnt_q  <= coal_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

endmodule

// File: tb/tb_multisim_client_quasi_static_push.sv
// Directed bench for multisim_client_quasi_static_push: one instance with the
// default parameters, one with MIN_INTERVAL=8 and PUSH_ON_RESET=0.
module tb_multisim_client_quasi_static_push;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1;
  logic        rst8 = 1'b1;
  logic [63:0] d0 = '0;
  logic [15:0] d8 = '0;
  logic        busy0, busy8;
  logic [31:0] push0, push8, coal0, coal8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multisim_client_quasi_static_push #(
    .DATA_WIDTH(64),
    .MIN_INTERVAL(0),
    .PUSH_ON_RESET(1'b1)
  ) dut0 (
    .clk                      (clk),
    .rst                      (rst0),
    .server_runtime_directory ("/tmp/multisim"),
    .server_name              ("cfg0"),
    .data                     (d0),
    .busy                     (busy0),
    .push_count               (push0),
    .coalesce_count           (coal0)
  );

  multisim_client_quasi_static_push #(
    .DATA_WIDTH(16),
    .MIN_INTERVAL(8),
    .PUSH_ON_RESET(1'b0)
  ) dut8 (
    .clk                      (clk),
    .rst                      (rst8),
    .server_runtime_directory ("/tmp/multisim"),
    .server_name              ("cfg8"),
    .data                     (d8),
    .busy                     (busy8),
    .push_count               (push8),
    .coalesce_count           (coal8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_idx[$];
    logic [31:0] prev;

    force dut0.tx_rdy = 1'b1;
    force dut8.tx_rdy = 1'b1;
    step(2);

    // Reset state
    chk("rst_tx_vld", 64'(dut0.tx_vld_q), 64'd0);
    chk("rst_push", 64'(push0), 64'd0);
    chk("rst_coal", 64'(coal0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_state", 64'(dut0.state_q), 64'd0);

    // 1: push of 0 after reset
    rst0 = 1'b0;
    step(1);
    chk("t1_vld", 64'(dut0.tx_vld_q), 64'd1);
    chk("t1_data", dut0.tx_data_q, 64'd0);
    chk("t1_busy", 64'(busy0), 64'd1);
    step(1);
    chk("t1_push", 64'(push0), 64'd1);
    chk("t1_vld_low", 64'(dut0.tx_vld_q), 64'd0);
    step(3);
    chk("t1_idle_push", 64'(push0), 64'd1);
    chk("t1_idle_busy", 64'(busy0), 64'd0);

    // 2: change to 0xA5
    d0 = 64'hA5;
    step(1);
    chk("t2_vld", 64'(dut0.tx_vld_q), 64'd1);
    chk("t2_data", dut0.tx_data_q, 64'hA5);
    step(1);
    chk("t2_push", 64'(push0), 64'd2);
    chk("t2_last", dut0.last_sent_q, 64'hA5);

    // 3: stalled send with coalesced updates
    force dut0.tx_rdy = 1'b0;
    d0 = 64'h1;
    step(1);
    chk("t3_vld", 64'(dut0.tx_vld_q), 64'd1);
    d0 = 64'h2;
    step(1);
    d0 = 64'h3;
    step(1);
    step(7);
    chk("t3_hold_data", dut0.tx_data_q, 64'h1);
    chk("t3_hold_vld", 64'(dut0.tx_vld_q), 64'd1);
    chk("t3_coal", 64'(coal0), 64'd2);
    chk("t3_push_stalled", 64'(push0), 64'd2);
    force dut0.tx_rdy = 1'b1;
    step(1);
    chk("t3_acc1_push", 64'(push0), 64'd3);
    chk("t3_acc1_last", dut0.last_sent_q, 64'h1);
    chk("t3_acc1_vld", 64'(dut0.tx_vld_q), 64'd0);
    step(1);
    chk("t3_second_vld", 64'(dut0.tx_vld_q), 64'd1);
    chk("t3_second_data", dut0.tx_data_q, 64'h3);
    step(1);
    chk("t3_acc2_push", 64'(push0), 64'd4);
    chk("t3_acc2_last", dut0.last_sent_q, 64'h3);

    // 6: reset in the middle of a stalled send
    force dut0.tx_rdy = 1'b0;
    d0 = 64'h77;
    step(1);
    chk("t6_vld", 64'(dut0.tx_vld_q), 64'd1);
    step(2);
    rst0 = 1'b1;
    step(1);
    chk("t6_vld_low", 64'(dut0.tx_vld_q), 64'd0);
    chk("t6_push", 64'(push0), 64'd0);
    chk("t6_coal", 64'(coal0), 64'd0);
    chk("t6_state", 64'(dut0.state_q), 64'd0);
    chk("t6_busy", 64'(busy0), 64'd0);
    rst0 = 1'b0;
    force dut0.tx_rdy = 1'b1;
    step(1);
    chk("t6_repush_data", dut0.tx_data_q, 64'h77);
    step(1);
    chk("t6_repush_count", 64'(push0), 64'd1);

    // PUSH_ON_RESET=0: no push of 0 after reset
    rst8 = 1'b0;
    step(5);
    chk("por0_push", 64'(push8), 64'd0);
    chk("por0_busy", 64'(busy8), 64'd0);

    // 4: MIN_INTERVAL=8, data changes every cycle
    prev = push8;
    for (int i = 0; i < 40; i++) begin
      d8 = 16'(i + 1);
      step(1);
      if (push8 != prev) acc_idx.push_back(i);
      prev = push8;
    end
    chk("t4_n_accepts", 64'(acc_idx.size()), 64'd5);
    if (acc_idx.size() >= 4) begin
      chk("t4_first_acc", 64'(acc_idx[0]), 64'd1);
      for (int k = 1; k < 4; k++) begin
        chk("t4_spacing", 64'(acc_idx[k] - acc_idx[k-1]), 64'd9);
      end
    end
    chk("t4_last", 64'(dut8.last_sent_q), 64'd37);
    chk("t4_coal", 64'(coal8), 64'd35);
    step(20);
    chk("t4_final_push", 64'(push8), 64'd6);
    chk("t4_final_last", 64'(dut8.last_sent_q), 64'd40);
    chk("t4_final_busy", 64'(busy8), 64'd0);

    // 5: change and return to last_sent during holdoff
    d8 = 16'h5;
    step(1);
    chk("t5_vld", 64'(dut8.tx_vld_q), 64'd1);
    step(1);
    chk("t5_push", 64'(push8), 64'd7);
    d8 = 16'h6;
    step(1);
    d8 = 16'h5;
    step(1);
    step(12);
    chk("t5_no_extra_push", 64'(push8), 64'd7);
    chk("t5_coal", 64'(coal8), 64'd37);
    chk("t5_busy", 64'(busy8), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
